// File: rtl/cpu_datapath_if.sv
// Controller <-> execute-stage datapath bundle: every select/enable going in,
// result, flags, store data, PC and debug read coming back.
interface cpu_datapath_if;
  logic [31:0] LR_in;
  logic        sel_load_LR;
  logic [3:0]  w_addr1;
  logic        w_en1;
  logic [3:0]  w_addr2;
  logic        w_en2;
  logic [3:0]  w_addr_ldr;
  logic        w_en_ldr;
  logic [31:0] w_data_ldr;
  logic [3:0]  A_addr;
  logic [3:0]  B_addr;
  logic [3:0]  shift_addr;
  logic [3:0]  str_addr;
  logic [3:0]  reg_addr;
  logic [1:0]  sel_pc;
  logic        load_pc;
  logic [10:0] start_pc;
  logic [1:0]  sel_A_in;
  logic [1:0]  sel_B_in;
  logic [1:0]  sel_shift_in;
  logic        en_A;
  logic        en_B;
  logic        en_S;
  logic [31:0] shift_imme;
  logic        sel_shift;
  logic [1:0]  shift_op;
  logic        sel_A;
  logic        sel_B;
  logic        sel_post_indexing;
  logic [31:0] imme_data;
  logic [2:0]  ALU_op;
  logic        en_status;
  logic        status_rdy;
  logic [31:0] datapath_out;
  logic [31:0] status_out;
  logic [31:0] str_data;
  logic [10:0] PC;
  logic [31:0] reg_output;

  modport master (
    output LR_in, sel_load_LR, w_addr1, w_en1, w_addr2, w_en2,
           w_addr_ldr, w_en_ldr, w_data_ldr, A_addr, B_addr, shift_addr,
           str_addr, reg_addr, sel_pc, load_pc, start_pc, sel_A_in, sel_B_in,
           sel_shift_in, en_A, en_B, en_S, shift_imme, sel_shift, shift_op,
           sel_A, sel_B, sel_post_indexing, imme_data, ALU_op, en_status,
           status_rdy,
    input  datapath_out, status_out, str_data, PC, reg_output
  );

  modport slave (
    input  LR_in, sel_load_LR, w_addr1, w_en1, w_addr2, w_en2,
           w_addr_ldr, w_en_ldr, w_data_ldr, A_addr, B_addr, shift_addr,
           str_addr, reg_addr, sel_pc, load_pc, start_pc, sel_A_in, sel_B_in,
           sel_shift_in, en_A, en_B, en_S, shift_imme, sel_shift, shift_op,
           sel_A, sel_B, sel_post_indexing, imme_data, ALU_op, en_status,
           status_rdy,
    output datapath_out, status_out, str_data, PC, reg_output
  );
endinterface

// File: rtl/cpu_datapath.sv
// ARM32 execute-stage datapath: 16x32 regfile, A/B/S latches, barrel shifter, ALU, NZCV, PC.
// Define DATAPATH_FWD_EN to build the 4-way operand-latch source muxes.
module cpu_datapath (
  input  logic         clk,
  input  logic         rst,
  cpu_datapath_if.slave bus
);

  logic [31:0] w_rf [16];
  logic [31:0] w_lat [3];
  logic [3:0]  w_lat_addr [3];
  logic        w_lat_en [3];
  logic [31:0] w_dp_out;
  logic [31:0] w_alu_res;
  logic [31:0] w_port1_data;
  logic [10:0] r_pc;
  logic [3:0]  r_flags;

  assign w_port1_data = bus.sel_load_LR ? bus.LR_in : w_dp_out;

  // Later conditions lose: ldr beats port 2 beats port 1 on the same address.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      logic [31:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_q <= '0;
        else if (bus.w_en_ldr && bus.w_addr_ldr == 4'(gi))
          r_q <= bus.w_data_ldr;
        else if (bus.w_en2 && bus.w_addr2 == 4'(gi))
          r_q <= w_alu_res;
        else if (bus.w_en1 && bus.w_addr1 == 4'(gi))
          r_q <= w_port1_data;
      end
      assign w_rf[gi] = r_q;
    end
  endgenerate

  assign w_lat_addr[0] = bus.A_addr;
  assign w_lat_addr[1] = bus.B_addr;
  assign w_lat_addr[2] = bus.shift_addr;
  assign w_lat_en[0]   = bus.en_A;
  assign w_lat_en[1]   = bus.en_B;
  assign w_lat_en[2]   = bus.en_S;

`ifdef DATAPATH_FWD_EN
  logic [1:0] w_lat_sel [3];
  assign w_lat_sel[0] = bus.sel_A_in;
  assign w_lat_sel[1] = bus.sel_B_in;
  assign w_lat_sel[2] = bus.sel_shift_in;
`else
  logic w_unused_sel;
  assign w_unused_sel = ^{bus.sel_A_in, bus.sel_B_in, bus.sel_shift_in};
`endif

  // Operand latches: index 0 = A, 1 = B, 2 = S.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lat
      logic [31:0] w_src;
      logic [31:0] r_q;
`ifdef DATAPATH_FWD_EN
      always_comb begin
        w_src = w_rf[w_lat_addr[gi]];
        case (w_lat_sel[gi])
          2'b01:   w_src = bus.w_data_ldr;
          2'b10:   w_src = w_dp_out;
          2'b11:   w_src = {21'b0, r_pc};
          default: w_src = w_rf[w_lat_addr[gi]];
        endcase
      end
`else
      assign w_src = w_rf[w_lat_addr[gi]];
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_q <= '0;
        else if (w_lat_en[gi])
          r_q <= w_src;
      end
      assign w_lat[gi] = r_q;
    end
  endgenerate

  logic [31:0] w_A, w_B, w_S;
  assign w_A = w_lat[0];
  assign w_B = w_lat[1];
  assign w_S = w_lat[2];

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic        w_unused_bits;
  assign w_shamt       = bus.sel_shift ? w_S[4:0] : bus.shift_imme[4:0];
  assign w_unused_bits = ^{w_S[31:5], bus.shift_imme[31:5]};

  always_comb begin
    w_shifted = w_B;
    if (w_shamt != 5'd0) begin
      case (bus.shift_op)
        2'b00:   w_shifted = w_B << w_shamt;
        2'b01:   w_shifted = w_B >> w_shamt;
        2'b10:   w_shifted = $signed(w_B) >>> w_shamt;
        default: w_shifted = (w_B >> w_shamt) | (w_B << (6'd32 - {1'b0, w_shamt}));
      endcase
    end
  end

  logic [31:0] w_a, w_b;
  logic [32:0] w_add, w_sub, w_rsb;
  logic        w_c, w_v;
  logic [3:0]  w_flags;
  assign w_a   = bus.sel_A ? 32'd0 : w_A;
  assign w_b   = bus.sel_B ? bus.imme_data : w_shifted;
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + 33'd1;
  assign w_rsb = {1'b0, w_b} + {1'b0, ~w_a} + 33'd1;

  // Subtractions are done as x + ~y + 1, so the carry out is already NOT borrow.
  always_comb begin
    w_alu_res = 32'd0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (bus.ALU_op)
      3'b000: begin
        w_alu_res = w_add[31:0];
        w_c       = w_add[32];
        w_v       = (w_a[31] == w_b[31]) && (w_add[31] != w_a[31]);
      end
      3'b001: begin
        w_alu_res = w_sub[31:0];
        w_c       = w_sub[32];
        w_v       = (w_a[31] != w_b[31]) && (w_sub[31] != w_a[31]);
      end
      3'b010: w_alu_res = w_a & w_b;
      3'b011: w_alu_res = w_a | w_b;
      3'b100: w_alu_res = w_a ^ w_b;
      3'b101: w_alu_res = w_b;
      3'b110: w_alu_res = ~w_b;
      default: begin
        w_alu_res = w_rsb[31:0];
        w_c       = w_rsb[32];
        w_v       = (w_b[31] != w_a[31]) && (w_rsb[31] != w_b[31]);
      end
    endcase
  end

  assign w_flags  = {w_alu_res[31], (w_alu_res == 32'd0), w_c, w_v};
  assign w_dp_out = bus.sel_post_indexing ? w_a : w_alu_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_flags <= 4'd0;
    else if (bus.en_status)
      r_flags <= w_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc <= 11'd0;
    else if (bus.load_pc) begin
      case (bus.sel_pc)
        2'b00:   r_pc <= r_pc + 11'd1;
        2'b01:   r_pc <= bus.start_pc;
        2'b10:   r_pc <= w_dp_out[10:0];
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign bus.datapath_out = w_dp_out;
  assign bus.status_out   = {(bus.status_rdy ? w_flags : r_flags), 28'd0};
  assign bus.str_data     = w_rf[bus.str_addr];
  assign bus.reg_output   = w_rf[bus.reg_addr];
  assign bus.PC           = r_pc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed scoreboard bench for cpu_datapath: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_cpu_datapath;
  logic clk;
  logic rst;
  cpu_datapath_if bus ();

  cpu_datapath u_dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_DP = 0, K_ST = 1, K_STR = 2, K_PC = 3, K_REG = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] sample(int k);
    case (k)
      K_DP:    return bus.datapath_out;
      K_ST:    return bus.status_out;
      K_STR:   return bus.str_data;
      K_PC:    return {21'b0, bus.PC};
      default: return bus.reg_output;
    endcase
  endfunction

  // Monitor: every queued expectation is judged at the next falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = sample(e.kind);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got=0x%08h want=0x%08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, act);
      end
    end
  end

  task automatic expect_out(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending want=0", q.size());
      q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lr(input logic [3:0] a, input logic [31:0] d);
    bus.w_en1 = 1'b1; bus.sel_load_LR = 1'b1; bus.w_addr1 = a; bus.LR_in = d;
    step();
    bus.w_en1 = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sop;
    logic [31:0] amt;
    logic [2:0]  op;
    logic        sa;
    logic [31:0] dp;
    logic [31:0] st;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    bus.LR_in = '0; bus.sel_load_LR = 0; bus.w_addr1 = '0; bus.w_en1 = 0;
    bus.w_addr2 = '0; bus.w_en2 = 0; bus.w_addr_ldr = '0; bus.w_en_ldr = 0;
    bus.w_data_ldr = '0; bus.A_addr = '0; bus.B_addr = '0; bus.shift_addr = '0;
    bus.str_addr = '0; bus.reg_addr = '0; bus.sel_pc = '0; bus.load_pc = 0;
    bus.start_pc = '0; bus.sel_A_in = '0; bus.sel_B_in = '0; bus.sel_shift_in = '0;
    bus.en_A = 0; bus.en_B = 0; bus.en_S = 0; bus.shift_imme = '0; bus.sel_shift = 0;
    bus.shift_op = '0; bus.sel_A = 0; bus.sel_B = 0; bus.sel_post_indexing = 0;
    bus.imme_data = '0; bus.ALU_op = '0; bus.en_status = 0; bus.status_rdy = 0;

    // Reset state
    expect_out(K_PC, 32'd0, "rst_pc");
    expect_out(K_ST, 32'd0, "rst_status");
    expect_out(K_REG, 32'd0, "rst_reg");
    expect_out(K_STR, 32'd0, "rst_str");
    expect_out(K_DP, 32'd0, "rst_dp");
    drain();
    rst = 1'b0;
    step();

    // rN = N through port 1; same-cycle read still sees the old value
    for (int n = 0; n < 16; n++) begin
      bus.w_en1 = 1'b1; bus.sel_load_LR = 1'b1;
      bus.w_addr1 = 4'(n); bus.LR_in = 32'(n); bus.reg_addr = 4'(n);
      expect_out(K_REG, 32'd0, $sformatf("old_r%0d", n));
      drain();
      step();
    end
    bus.w_en1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      bus.reg_addr = 4'(n);
      bus.str_addr = 4'(15 - n);
      expect_out(K_REG, 32'(n), $sformatf("reg_r%0d", n));
      expect_out(K_STR, 32'(15 - n), $sformatf("str_r%0d", 15 - n));
      drain();
    end

    // A=r1, B=r2, S=r1, LSL by S, ADD -> 1 + (2<<1) = 5
    bus.A_addr = 4'd1; bus.B_addr = 4'd2; bus.shift_addr = 4'd1;
    bus.en_A = 1; bus.en_B = 1; bus.en_S = 1;
    step();
    bus.en_A = 0; bus.en_B = 0; bus.en_S = 0;
    bus.sel_shift = 1; bus.shift_op = 2'b00; bus.ALU_op = 3'b000; bus.en_status = 1;
    expect_out(K_DP, 32'd5, "add_lsl");
    drain();
    step();
    bus.en_status = 0;
    expect_out(K_ST, 32'd0, "add_flags");
    drain();

    // 0 - 12, bypass flags, write back to r0 via port 1
    bus.sel_A = 1; bus.sel_B = 1; bus.imme_data = 32'd12; bus.ALU_op = 3'b001;
    bus.status_rdy = 1; bus.en_status = 1;
    bus.w_en1 = 1; bus.w_addr1 = 4'd0; bus.sel_load_LR = 0;
    expect_out(K_DP, 32'hFFFF_FFF4, "sub_neg");
    expect_out(K_ST, 32'h8000_0000, "sub_neg_bypass");
    drain();
    step();
    bus.w_en1 = 0; bus.en_status = 0; bus.status_rdy = 0; bus.reg_addr = 4'd0;
    expect_out(K_ST, 32'h8000_0000, "sub_neg_reg");
    expect_out(K_REG, 32'hFFFF_FFF4, "wb_r0");
    drain();

    // B = r0 (-12), 0 - B = 12
    bus.B_addr = 4'd0; bus.en_B = 1;
    step();
    bus.en_B = 0;
    bus.sel_A = 1; bus.sel_B = 0; bus.sel_shift = 0; bus.shift_imme = 0;
    bus.ALU_op = 3'b001; bus.en_status = 1;
    expect_out(K_DP, 32'd12, "neg_neg");
    drain();
    step();
    bus.en_status = 0;
    expect_out(K_ST, 32'd0, "neg_neg_flags");
    drain();

    // 0x7FFFFFFF + 1 -> N, V
    write_lr(4'd5, 32'h7FFF_FFFF);
    bus.A_addr = 4'd5; bus.en_A = 1;
    step();
    bus.en_A = 0;
    bus.sel_A = 0; bus.sel_B = 1; bus.imme_data = 32'd1; bus.ALU_op = 3'b000;
    bus.status_rdy = 1;
    expect_out(K_DP, 32'h8000_0000, "add_ovf");
    expect_out(K_ST, 32'h9000_0000, "add_ovf_flags");
    drain();

    // 5 - 5 -> Z, C; also registered
    write_lr(4'd6, 32'd5);
    bus.A_addr = 4'd6; bus.en_A = 1;
    step();
    bus.en_A = 0;
    bus.imme_data = 32'd5; bus.ALU_op = 3'b001; bus.en_status = 1;
    expect_out(K_DP, 32'd0, "sub_zero");
    expect_out(K_ST, 32'h6000_0000, "sub_zero_bypass");
    drain();
    step();
    bus.en_status = 0; bus.status_rdy = 0;
    expect_out(K_ST, 32'h6000_0000, "sub_zero_reg");
    drain();

    // Shifter and remaining ALU ops: B = 0x80000010, A = 5
    write_lr(4'd7, 32'h8000_0010);
    bus.B_addr = 4'd7; bus.en_B = 1;
    step();
    bus.en_B = 0;
    bus.sel_B = 0; bus.sel_shift = 0; bus.status_rdy = 1;
    vecs = '{
      '{2'b01, 32'd4,  3'b101, 1'b1, 32'h0800_0001, 32'h0000_0000},
      '{2'b10, 32'd4,  3'b101, 1'b1, 32'hF800_0001, 32'h8000_0000},
      '{2'b11, 32'd8,  3'b101, 1'b1, 32'h1080_0000, 32'h0000_0000},
      '{2'b00, 32'd1,  3'b101, 1'b1, 32'h0000_0020, 32'h0000_0000},
      '{2'b00, 32'd32, 3'b101, 1'b1, 32'h8000_0010, 32'h8000_0000},
      '{2'b11, 32'd0,  3'b110, 1'b1, 32'h7FFF_FFEF, 32'h0000_0000},
      '{2'b00, 32'd0,  3'b010, 1'b0, 32'h0000_0000, 32'h4000_0000},
      '{2'b00, 32'd0,  3'b011, 1'b0, 32'h8000_0015, 32'h8000_0000},
      '{2'b00, 32'd0,  3'b100, 1'b0, 32'h8000_0015, 32'h8000_0000},
      '{2'b00, 32'd0,  3'b111, 1'b0, 32'h8000_000B, 32'hA000_0000},
      '{2'b00, 32'd4,  3'b000, 1'b0, 32'h0000_0105, 32'h0000_0000}
    };
    foreach (vecs[i]) begin
      bus.shift_op = vecs[i].sop; bus.shift_imme = vecs[i].amt;
      bus.ALU_op = vecs[i].op; bus.sel_A = vecs[i].sa;
      expect_out(K_DP, vecs[i].dp, $sformatf("vec%0d_dp", i));
      expect_out(K_ST, vecs[i].st, $sformatf("vec%0d_flags", i));
      drain();
    end
    bus.status_rdy = 0;

    // Post-indexing passes the A operand
    bus.sel_post_indexing = 1; bus.sel_A = 0;
    expect_out(K_DP, 32'd5, "post_idx_a");
    drain();
    bus.sel_A = 1;
    expect_out(K_DP, 32'd0, "post_idx_zero");
    drain();
    bus.sel_post_indexing = 0;

    // Write-port priority
    bus.ALU_op = 3'b101; bus.sel_B = 1; bus.imme_data = 32'h222;
    bus.w_en1 = 1; bus.sel_load_LR = 1; bus.LR_in = 32'h111; bus.w_addr1 = 4'd8;
    bus.w_en2 = 1; bus.w_addr2 = 4'd8;
    bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd8; bus.w_data_ldr = 32'h333;
    step();
    bus.w_en_ldr = 0; bus.w_addr1 = 4'd9; bus.w_addr2 = 4'd9;
    step();
    bus.w_en1 = 0; bus.w_en2 = 0;
    bus.reg_addr = 4'd8; bus.str_addr = 4'd9;
    expect_out(K_REG, 32'h333, "prio_ldr");
    expect_out(K_STR, 32'h222, "prio_p2");
    drain();

    // B latch source select (honoured only with forwarding built)
    bus.w_data_ldr = 32'hABCD_1234; bus.sel_B_in = 2'b01; bus.B_addr = 4'd7; bus.en_B = 1;
    step();
    bus.en_B = 0; bus.sel_B_in = 2'b00;
    bus.sel_B = 0; bus.sel_A = 1; bus.shift_imme = 0; bus.ALU_op = 3'b101;
`ifdef DATAPATH_FWD_EN
    expect_out(K_DP, 32'hABCD_1234, "fwd_ldr");
`else
    expect_out(K_DP, 32'h8000_0010, "nofwd_regfile");
`endif
    drain();

    // PC
    bus.start_pc = 11'h7FF; bus.sel_pc = 2'b01; bus.load_pc = 1;
    step();
    expect_out(K_PC, 32'h7FF, "pc_start");
    drain();
    bus.sel_pc = 2'b00;
    step();
    expect_out(K_PC, 32'h000, "pc_wrap");
    drain();
    bus.sel_B = 1; bus.imme_data = 32'h0001_2345; bus.sel_pc = 2'b10;
    step();
    expect_out(K_PC, 32'h345, "pc_dp");
    drain();
    bus.sel_pc = 2'b11;
    step();
    expect_out(K_PC, 32'h345, "pc_hold_sel");
    drain();
    bus.sel_pc = 2'b00; bus.load_pc = 0;
    step();
    expect_out(K_PC, 32'h345, "pc_hold_en");
    drain();

    // Mid-cycle asynchronous reset
    step();
    #1;
    rst = 1'b1;
    bus.reg_addr = 4'd9; bus.str_addr = 4'd8;
    expect_out(K_PC, 32'd0, "arst_pc");
    expect_out(K_ST, 32'd0, "arst_status");
    expect_out(K_REG, 32'd0, "arst_r9");
    expect_out(K_STR, 32'd0, "arst_r8");
    drain();
    for (int k = 0; k < 8; k++) begin
      bus.reg_addr = 4'(2 * k);
      bus.str_addr = 4'(2 * k + 1);
      expect_out(K_REG, 32'd0, $sformatf("arst_r%0d", 2 * k));
      expect_out(K_STR, 32'd0, $sformatf("arst_r%0d", 2 * k + 1));
      drain();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
